strobe_byte_rx: RTL and testbench
=================================

# strobe_byte_rx

Input stage of the `tt_um_vlsi` user project. It accepts bytes from an off-chip host over a 4-phase strobe/acknowledge handshake: data arrives on `ui_in`, the strobe on `uio_in[0]`, and the acknowledge leaves on `uio_out[1]`. Accepted bytes are buffered in a small FIFO and presented to the core over a valid/ready interface. The block synchronises the asynchronous strobe, applies back-pressure by withholding the acknowledge, and never drops or duplicates a byte, including across reset.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: strobe synchroniser flops; ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ena`  in  1  design selected. While low, no new handshake starts.
- `data_in`  in  8  host byte (from `ui_in`). Not synchronised.
- `stb_in`  in  1  host strobe (from `uio_in[0]`). Asynchronous.
- `ack_out`  out  1  acknowledge (to `uio_out[1]`). Registered.
- `stall_out`  out  1  high while a strobed byte waits for FIFO space.
- `m_data`  out  8  head-of-FIFO byte.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  core consumes the head when `m_valid & m_ready`.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Synchroniser:** `stb_in` passes through `SYNC_STAGES` flops, all reset to **1**. Its output is `stb_s`.
- **FSM states:**
  - `REARM` (reset state): wait for `stb_s==0`, then go to `IDLE`.
  - `IDLE`: if `stb_s & ena`:
    - if space is available, push `data_in` and go to `ACK`;
    - otherwise go to `HOLD`.
  - `HOLD`: when space is available, push `data_in` and go to `ACK`. `ena` is ignored here, so an in-progress handshake always completes.
  - `ACK`: wait for `stb_s==0`, then go to `IDLE`.
- **Space available** means `level < DEPTH`, or (`level == DEPTH` and a pop happens in the same cycle).
- **Outputs from state:** `ack_out = (state==ACK)` and `stall_out = (state==HOLD)`, both driven from registered state.
- **Host contract:**
  - hold `data_in` stable from `stb_in` rise until `ack_out` rise;
  - drop `stb_in` only after `ack_out` rises;
  - raise `stb_in` again only after `ack_out` falls.
- **FIFO behaviour:**
  - circular buffer with read and write pointers of `$clog2(DEPTH)` bits that wrap modulo `DEPTH`;
  - `level` is a separate counter;
  - `m_data = mem[rd_ptr]`, `m_valid = (level != 0)`;
  - a pop when empty is ignored;
  - a simultaneous push and pop leaves `level` unchanged.
- **Duplicate suppression across reset:** the synchroniser resets to 1 and the FSM resets to `REARM`. A strobe still high when reset is released is therefore not re-captured. The host must complete that handshake, and `ack_out` stays 0 during it.
- **Reset values:** `ack_out=0`, `stall_out=0`, `m_valid=0`, `level=0`. `m_data` is don't-care. Pointers are 0.

## Timing
- `stb_in` high before edge k gives `stb_s` high after edge k+SYNC_STAGES−1.
- In `IDLE` with space, the push happens at edge k+SYNC_STAGES. `ack_out` and `m_valid` are high after that same edge.
- `stb_in` low before edge j gives `ack_out` low after edge j+SYNC_STAGES.
- One handshake takes at least 2·SYNC_STAGES+2 cycles, so the FIFO fills no faster than one byte per handshake.
- Fall-through latency from push to `m_valid` is 0 extra cycles: `m_valid` rises on the edge after the push.
- In `HOLD` with a full FIFO, a pop at edge n performs the push at the same edge n. `ack_out` rises after edge n.
- Asserting `rst_n` low mid-handshake clears `ack_out` and the FIFO immediately, without waiting for a clock.

## Structure
- **Package `strobe_rx_pkg`:**
  - state enum `rx_state_e {REARM, IDLE, HOLD, ACK}`;
  - `DEFAULT_DEPTH = 4`;
  - `DEFAULT_SYNC = 2`.
- **Sub-module `byte_fifo`:**
  - parameter `DEPTH`;
  - ports `push`, `wdata`, `pop`, `rdata`, `empty`, `full`, `level`.
- The top module holds only the synchroniser and the FSM.

## Test plan
- **Reset with strobe high:** hold `stb_in=1` through reset release.
  - Required: no push, `level=0`, `ack_out=0`.
  - After the host drops `stb_in`, a new strobe with 0x5A gives `level=1` and `m_data=0x5A`.
- **Single handshake latency:** with SYNC_STAGES=2, raise `stb_in` before edge k with `data_in=0xA5`.
  - Required: `ack_out` and `m_valid` are high after edge k+2, with `m_data=0xA5`.
  - Required: `ack_out` falls 3 edges after `stb_in` falls.
- **Fill and stall:** with `m_ready=0`, send 0x01..0x04.
  - Required: `level=4`.
  - A fifth strobe with 0x05 gives `stall_out=1` and `ack_out=0`.
  - Pulsing `m_ready` for one cycle pops 0x01 and pushes 0x05 at the same edge. `level` stays 4 and `ack_out` rises.
- **Order and wrap-around:** stream 10 bytes 0x10..0x19 with `m_ready` toggling every cycle.
  - Required: the core receives exactly 0x10..0x19 in order, with no duplicates and no losses.
- **ena gating:** with `ena=0`, raise `stb_in`.
  - Required: the FSM stays in `IDLE` and `ack_out=0`.
  - Raising `ena` completes the push.
  - Dropping `ena` during `HOLD` still lets that handshake complete.
- **Reset mid-operation:** with `level=3` and `ack_out=1`, pulse `rst_n` low between clock edges.
  - Required: `ack_out`, `m_valid` and `level` are 0 immediately.
  - After release the FSM is in `REARM` until `stb_in` is low.

Source files
------------

// File: rtl/strobe_rx_pkg.sv
// strobe_byte_rx shared types and defaults.
// Host strobe/ack receiver for the tt_um_vlsi input stage.
package strobe_rx_pkg;

  typedef enum logic [1:0] {
    REARM,
    IDLE,
    HOLD,
    ACK
  } rx_state_e;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_SYNC  = 2;

endpackage

// File: rtl/byte_fifo.sv
// Small circular byte FIFO with a separate occupancy counter.
// Head byte is visible combinationally on rdata.
module byte_fifo
  import strobe_rx_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop on empty is dropped; a push on full
  // only lands when the head leaves this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/strobe_byte_rx.sv
// Strobe synchroniser and 4-phase handshake FSM
// feeding a byte FIFO toward the core.
module strobe_byte_rx
  import strobe_rx_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [7:0]             data_in,
  input  logic                   stb_in,
  output logic                   ack_out,
  output logic                   stall_out,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stb_s;
  rx_state_e              state_q, state_d;
  logic                   ack_q, stall_q;
  logic                   push;
  logic                   space;
  logic                   empty;
  logic                   full;

  assign stb_s = sync_q[SYNC_STAGES-1];

  // Synchroniser resets high so a strobe held
  // across reset is never seen as a new edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], stb_in};
    end
  end

  // Room exists if not full, or the head pops now.
  assign space = ~full | (m_ready & ~empty);

  // Next-state and push decode.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      REARM: begin
        if (!stb_s) state_d = IDLE;
      end
      IDLE: begin
        if (stb_s && ena) begin
          if (space) begin
            push    = 1'b1;
            state_d = ACK;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (space) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!stb_s) state_d = IDLE;
      end
      default: state_d = REARM;
    endcase
  end

  // State plus glitch-free registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REARM;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
      stall_q <= (state_d == HOLD);
    end
  end

  assign ack_out   = ack_q;
  assign stall_out = stall_q;
  assign m_valid   = ~empty;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (data_in),
    .pop   (m_ready),
    .rdata (m_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_strobe_byte_rx.sv
// Bench for strobe_byte_rx: host driver, core sink,
// and a queue model of bytes accepted versus consumed.
module tb_strobe_byte_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       stb_in = 1'b0;
  logic       ack_out;
  logic       stall_out;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  strobe_byte_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .data_in   (data_in),
    .stb_in    (stb_in),
    .ack_out   (ack_out),
    .stall_out (stall_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Core sink: record every byte actually consumed.
  always @(posedge clk) begin
    if (rst_n && m_valid === 1'b1 && m_ready === 1'b1)
      got_q.push_back(m_data);
  end

  task automatic wait_ack(input logic val, input int budget,
                          output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      if (ack_out === val) ok = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit ok;
    @(negedge clk);
    data_in = d;
    stb_in  = 1'b1;
    wait_ack(1'b1, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_ack_rise byte=%02h ack=%b want 1",
               d, ack_out);
    end else begin
      exp_q.push_back(d);
    end
    stb_in = 1'b0;
    wait_ack(1'b0, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_ack_fall byte=%02h ack=%b want 0",
               d, ack_out);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    m_ready = 1'b1;
    while (m_valid !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    stb_in  = 1'b1;
    data_in = 8'hEE;
    repeat (3) @(negedge clk);
    checks++;
    if (ack_out !== 1'b0 || m_valid !== 1'b0 ||
        level !== 3'd0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_vals ack=%b valid=%b lvl=%0d stall=%b want 0",
               ack_out, m_valid, level, stall_out);
    end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (ack_out !== 1'b0 || level !== 3'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_stb_high ack=%b lvl=%0d valid=%b want 0",
               ack_out, level, m_valid);
    end
    stb_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_out !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL rst_stb_drop ack=%b lvl=%0d want 0",
               ack_out, level);
    end
    exp_q.delete();
    got_q.delete();
    send_byte(8'h5A);
    checks++;
    if (level !== 3'd1 || m_data !== 8'h5A) begin
      errors++;
      $display("FAIL rst_first lvl=%0d data=%02h want 1 5a",
               level, m_data);
    end
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      errors++;
      $display("FAIL rst_first_pop n=%0d want 1 byte 5a",
               got_q.size());
    end
  endtask

  task automatic test_latency();
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    data_in = 8'hA5;
    stb_in  = 1'b1;
    @(negedge clk);
    checks++;
    if (ack_out !== 1'b0) begin
      errors++;
      $display("FAIL lat_k ack=%b want 0", ack_out);
    end
    @(negedge clk);
    checks++;
    if (ack_out !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_k1 ack=%b valid=%b want 0 0",
               ack_out, m_valid);
    end
    @(negedge clk);
    checks++;
    if (ack_out !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'hA5) begin
      errors++;
      $display("FAIL lat_k2 ack=%b valid=%b data=%02h want 1 1 a5",
               ack_out, m_valid, m_data);
    end
    exp_q.push_back(8'hA5);
    stb_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack_out !== 1'b1) begin
      errors++;
      $display("FAIL lat_fall_early ack=%b want 1", ack_out);
    end
    @(negedge clk);
    checks++;
    if (ack_out !== 1'b0) begin
      errors++;
      $display("FAIL lat_fall ack=%b want 0", ack_out);
    end
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors++;
      $display("FAIL lat_pop n=%0d want 1 byte a5", got_q.size());
    end
  endtask

  task automatic test_fill_stall();
    bit ok;
    exp_q.delete();
    got_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    checks++;
    if (level !== 3'd4) begin
      errors++;
      $display("FAIL fill_level lvl=%0d want 4", level);
    end
    @(negedge clk);
    data_in = 8'h05;
    stb_in  = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (stall_out !== 1'b1 || ack_out !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL fill_stall stall=%b ack=%b lvl=%0d want 1 0 4",
               stall_out, ack_out, level);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (level !== 3'd4 || ack_out !== 1'b1 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL fill_swap lvl=%0d ack=%b stall=%b want 4 1 0",
               level, ack_out, stall_out);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h01 || m_data !== 8'h02) begin
      errors++;
      $display("FAIL fill_pop n=%0d head=%02h want 1 popped, head 02",
               got_q.size(), m_data);
    end
    exp_q.push_back(8'h05);
    stb_in = 1'b0;
    wait_ack(1'b0, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fill_ack_fall ack=%b want 0", ack_out);
    end
    drain();
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL fill_count got=%0d want 5", got_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL fill_order idx=%0d got=%02h want %02h",
                 i, got_q[i], i + 1);
      end
    end
  endtask

  task automatic test_order_wrap();
    bit done;
    exp_q.delete();
    got_q.delete();
    done    = 1'b0;
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          m_ready = ~m_ready;
        end
        m_ready = 1'b0;
      end
    join
    drain();
    checks++;
    if (got_q.size() != 10) begin
      errors++;
      $display("FAIL wrap_count got=%0d want 10", got_q.size());
    end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL wrap_order idx=%0d got=%02h want %02h",
                 i, got_q[i], 8'h10 + i);
      end
    end
  endtask

  task automatic test_ena();
    bit ok;
    int n;
    exp_q.delete();
    got_q.delete();
    m_ready = 1'b0;
    ena     = 1'b0;
    @(negedge clk);
    data_in = 8'h33;
    stb_in  = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (ack_out !== 1'b0 || stall_out !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL ena_gate ack=%b stall=%b lvl=%0d want 0 0 0",
               ack_out, stall_out, level);
    end
    ena = 1'b1;
    wait_ack(1'b1, 20, ok);
    checks++;
    if (!ok || level !== 3'd1 || m_data !== 8'h33) begin
      errors++;
      $display("FAIL ena_resume ack=%b lvl=%0d data=%02h want 1 1 33",
               ack_out, level, m_data);
    end
    exp_q.push_back(8'h33);
    stb_in = 1'b0;
    wait_ack(1'b0, 20, ok);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    @(negedge clk);
    data_in = 8'h77;
    stb_in  = 1'b1;
    n = 0;
    while (stall_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL ena_hold stall=%b want 1", stall_out);
    end
    ena = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (stall_out !== 1'b1 || ack_out !== 1'b0) begin
      errors++;
      $display("FAIL ena_hold_keep stall=%b ack=%b want 1 0",
               stall_out, ack_out);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (ack_out !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("FAIL ena_hold_done ack=%b lvl=%0d want 1 4",
               ack_out, level);
    end
    exp_q.push_back(8'h77);
    stb_in = 1'b0;
    wait_ack(1'b0, 20, ok);
    ena = 1'b1;
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ena_count got=%0d want %0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ena_order idx=%0d got=%02h want %02h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit done;
    exp_q.delete();
    got_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_byte(8'($urandom_range(0, 255)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b0;
      end
    join
    drain();
    checks++;
    if (got_q.size() != 24 || exp_q.size() != 24) begin
      errors++;
      $display("FAIL rand_count got=%0d sent=%0d want 24",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_order idx=%0d got=%02h want %02h",
                 i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL rand_level lvl=%0d want 0", level);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_q.delete();
    got_q.delete();
    m_ready = 1'b0;
    send_byte(8'h21);
    send_byte(8'h42);
    @(negedge clk);
    data_in = 8'hC3;
    stb_in  = 1'b1;
    wait_ack(1'b1, 20, ok);
    checks++;
    if (!ok || level !== 3'd3) begin
      errors++;
      $display("FAIL mid_setup ack=%b lvl=%0d want 1 3", ack_out, level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack_out !== 1'b0 || m_valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL mid_async ack=%b valid=%b lvl=%0d want 0 0 0",
               ack_out, m_valid, level);
    end
    exp_q.delete();
    got_q.delete();
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (ack_out !== 1'b0 || level !== 3'd0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_rearm ack=%b lvl=%0d stall=%b want 0 0 0",
               ack_out, level, stall_out);
    end
    stb_in = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h99);
    checks++;
    if (level !== 3'd1 || m_data !== 8'h99) begin
      errors++;
      $display("FAIL mid_after lvl=%0d data=%02h want 1 99",
               level, m_data);
    end
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h99) begin
      errors++;
      $display("FAIL mid_pop n=%0d want 1 byte 99", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_stall();
    test_order_wrap();
    test_ena();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
